// File: rtl/fir_tap_sequencer_if.sv
// rtl/fir_tap_sequencer_if.sv - request and address-pair bundle for the FIR tap sequencer
// Purpose: groups the pass request (start, wr_ptr, en) and the issued
// address-pair stream (busy, valid, fwd_addr, rev_addr, coef_idx, center,
// last, done) of fir_tap_sequencer.
// Modports: master drives the request side, slave (the sequencer) drives
// the address-pair side.
interface fir_tap_sequencer_if #(
    parameter int ADDR_W = 4
);
    logic              start;
    logic [ADDR_W-1:0] wr_ptr;
    logic              en;
    logic              busy;
    logic              valid;
    logic [ADDR_W-1:0] fwd_addr;
    logic [ADDR_W-1:0] rev_addr;
    logic [ADDR_W-1:0] coef_idx;
    logic              center;
    logic              last;
    logic              done;

    modport master (
        output start, wr_ptr, en,
        input  busy, valid, fwd_addr, rev_addr, coef_idx, center, last, done
    );

    modport slave (
        input  start, wr_ptr, en,
        output busy, valid, fwd_addr, rev_addr, coef_idx, center, last, done
    );
endinterface

// File: rtl/fir_tap_sequencer.sv
// rtl/fir_tap_sequencer.sv - symmetric-FIR sample/coefficient address pair sequencer
// Purpose: for each output sample, walks a circular sample buffer from both
// ends towards the middle, issuing one (newest-side, oldest-side, coefficient)
// address triple per enabled cycle so a symmetric FIR can pre-add pairs.
// Ports:
//   clk  - sole clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - slave modport: start/wr_ptr/en in; busy/valid/fwd_addr/rev_addr/
//          coef_idx/center/last/done out, all registered
module fir_tap_sequencer #(
    parameter int NUM_TAPS = 16,
    parameter int ADDR_W   = $clog2(NUM_TAPS)
) (
    input logic                clk,
    input logic                rst,
    fir_tap_sequencer_if.slave bus
);
    localparam int                PAIRS  = (NUM_TAPS + 1) / 2;
    localparam logic [ADDR_W-1:0] LAST_I = ADDR_W'(PAIRS - 1);
    // TAPS_N may truncate to 0 when NUM_TAPS is a power of two; the modular
    // arithmetic below still comes out exact in that case.
    localparam logic [ADDR_W-1:0] TAPS_N = ADDR_W'(NUM_TAPS);
    localparam logic [ADDR_W:0]   TAPS_X = (ADDR_W + 1)'(NUM_TAPS);
    localparam bit                ODD    = (NUM_TAPS % 2) == 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state;
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] i;

    logic [ADDR_W-1:0] fwd_next;
    logic [ADDR_W-1:0] rev_next;
    logic [ADDR_W:0]   rev_sum;

    // Explicit wrap compares so non-power-of-two buffer sizes wrap at
    // NUM_TAPS rather than at 2**ADDR_W.
    always_comb begin
        fwd_next = (base < i) ? (base + TAPS_N - i) : (base - i);
        rev_sum  = {1'b0, base} + {1'b0, i} + (ADDR_W + 1)'(1);
        rev_next = (rev_sum >= TAPS_X) ? (base + i + ADDR_W'(1) - TAPS_N)
                                       : (base + i + ADDR_W'(1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            base         <= '0;
            i            <= '0;
            bus.busy     <= 1'b0;
            bus.valid    <= 1'b0;
            bus.fwd_addr <= '0;
            bus.rev_addr <= '0;
            bus.coef_idx <= '0;
            bus.center   <= 1'b0;
            bus.last     <= 1'b0;
            bus.done     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        base     <= bus.wr_ptr;
                        i        <= '0;
                        bus.busy <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    // The final pair is already on the outputs, so this edge
                    // moves on to DONE regardless of en.
                    if (bus.last) begin
                        bus.valid  <= 1'b0;
                        bus.last   <= 1'b0;
                        bus.center <= 1'b0;
                        bus.done   <= 1'b1;
                        state      <= DONE;
                    end else if (bus.en) begin
                        bus.fwd_addr <= fwd_next;
                        bus.rev_addr <= rev_next;
                        bus.coef_idx <= i;
                        bus.valid    <= 1'b1;
                        bus.last     <= (i == LAST_I);
                        bus.center   <= ODD && (i == LAST_I);
                        i            <= i + ADDR_W'(1);
                    end else begin
                        bus.valid <= 1'b0;
                    end
                end
                DONE: begin
                    bus.done <= 1'b0;
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fir_tap_sequencer.sv
// tb/tb_fir_tap_sequencer.sv - directed self-checking bench for fir_tap_sequencer
module tb_fir_tap_sequencer;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    fir_tap_sequencer_if #(.ADDR_W(4)) b16 ();
    fir_tap_sequencer_if #(.ADDR_W(3)) b7 ();

    fir_tap_sequencer #(.NUM_TAPS(16), .ADDR_W(4)) dut16 (
        .clk (clk),
        .rst (rst),
        .bus (b16.slave)
    );

    fir_tap_sequencer #(.NUM_TAPS(7), .ADDR_W(3)) dut7 (
        .clk (clk),
        .rst (rst),
        .bus (b7.slave)
    );

    int compared   = 0;
    int mismatched = 0;
    int exp_i;
    int held_f;
    int held_r;
    int held_c;
    bit en_pat [10] = '{1, 0, 0, 1, 1, 0, 1, 0, 1, 1};
    int f7 [4]      = '{2, 1, 0, 6};
    int r7 [4]      = '{3, 4, 5, 6};

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk16(input string tag, input int v, input int f, input int r,
                         input int c, input int ce, input int l, input int d, input int b);
        chk({tag, ".valid"},  32'(b16.valid),    32'(v));
        chk({tag, ".fwd"},    32'(b16.fwd_addr), 32'(f));
        chk({tag, ".rev"},    32'(b16.rev_addr), 32'(r));
        chk({tag, ".coef"},   32'(b16.coef_idx), 32'(c));
        chk({tag, ".center"}, 32'(b16.center),   32'(ce));
        chk({tag, ".last"},   32'(b16.last),     32'(l));
        chk({tag, ".done"},   32'(b16.done),     32'(d));
        chk({tag, ".busy"},   32'(b16.busy),     32'(b));
    endtask

    task automatic chk7(input string tag, input int v, input int f, input int r,
                        input int c, input int ce, input int l, input int d, input int b);
        chk({tag, ".valid"},  32'(b7.valid),    32'(v));
        chk({tag, ".fwd"},    32'(b7.fwd_addr), 32'(f));
        chk({tag, ".rev"},    32'(b7.rev_addr), 32'(r));
        chk({tag, ".coef"},   32'(b7.coef_idx), 32'(c));
        chk({tag, ".center"}, 32'(b7.center),   32'(ce));
        chk({tag, ".last"},   32'(b7.last),     32'(l));
        chk({tag, ".done"},   32'(b7.done),     32'(d));
        chk({tag, ".busy"},   32'(b7.busy),     32'(b));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        b16.start = 1'b0; b16.wr_ptr = '0; b16.en = 1'b0;
        b7.start  = 1'b0; b7.wr_ptr  = '0; b7.en  = 1'b0;
        tick;
        tick;
        chk16("rst16", 0, 0, 0, 0, 0, 0, 0, 0);
        chk7("rst7", 0, 0, 0, 0, 0, 0, 0, 0);

        // 16 taps from wr_ptr=15 with en held high
        rst = 1'b0;
        b16.start = 1'b1; b16.wr_ptr = 4'd15; b16.en = 1'b1;
        tick;
        chk16("p1_accept", 0, 0, 0, 0, 0, 0, 0, 1);
        b16.start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick;
            chk16($sformatf("p1_pair%0d", k), 1, 15 - k, k, k, 0, (k == 7) ? 1 : 0, 0, 1);
        end
        tick;
        chk16("p1_done", 0, 8, 7, 7, 0, 0, 1, 1);

        // start during the done cycle is ignored, start in the following IDLE cycle is taken
        b16.start = 1'b1; b16.wr_ptr = 4'd3;
        tick;
        chk16("p1_idle", 0, 8, 7, 7, 0, 0, 0, 0);
        b16.wr_ptr = 4'd5;
        tick;
        chk16("p2_accept", 0, 8, 7, 7, 0, 0, 0, 1);

        // en stalls plus a second start with a different wr_ptr mid-pass
        held_f = 8; held_r = 7; held_c = 7; exp_i = 0;
        for (int k = 0; k < 30 && exp_i < 8; k++) begin
            b16.en     = en_pat[k % 10];
            b16.start  = (k == 2);
            b16.wr_ptr = (k == 2) ? 4'd9 : 4'd5;
            tick;
            if (b16.en) begin
                held_f = (5 - exp_i + 16) % 16;
                held_r = (6 + exp_i) % 16;
                held_c = exp_i;
                chk16($sformatf("p2_pair%0d", exp_i), 1, held_f, held_r, held_c, 0,
                      (exp_i == 7) ? 1 : 0, 0, 1);
                exp_i++;
            end else begin
                chk16($sformatf("p2_gap%0d", k), 0, held_f, held_r, held_c, 0, 0, 0, 1);
            end
        end
        chk("p2_pairs_issued", 32'(exp_i), 32'd8);
        b16.start = 1'b0; b16.en = 1'b1;
        tick;
        chk16("p2_done", 0, 14, 13, 7, 0, 0, 1, 1);
        tick;
        chk16("p2_idle", 0, 14, 13, 7, 0, 0, 0, 0);

        // 7 taps: odd length ends on a center tap
        b7.start = 1'b1; b7.wr_ptr = 3'd2; b7.en = 1'b1;
        tick;
        chk7("p7_accept", 0, 0, 0, 0, 0, 0, 0, 1);
        b7.start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick;
            chk7($sformatf("p7_pair%0d", k), 1, f7[k], r7[k], k,
                 (k == 3) ? 1 : 0, (k == 3) ? 1 : 0, 0, 1);
        end
        tick;
        chk7("p7_done", 0, 6, 6, 3, 0, 0, 1, 1);
        tick;
        chk7("p7_idle", 0, 6, 6, 3, 0, 0, 0, 0);

        // reset aborts a pass at pair 3 of 8, then a fresh pass restarts at i=0
        b16.start = 1'b1; b16.wr_ptr = 4'd4; b16.en = 1'b1;
        tick;
        b16.start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick;
            chk16($sformatf("p4_pair%0d", k), 1, 4 - k, 5 + k, k, 0, 0, 0, 1);
        end
        rst = 1'b1; b16.start = 1'b1;
        tick;
        chk16("p4_abort", 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0; b16.start = 1'b0;
        tick;
        chk16("p4_no_done", 0, 0, 0, 0, 0, 0, 0, 0);
        b16.start = 1'b1; b16.wr_ptr = 4'd10;
        tick;
        chk16("p5_accept", 0, 0, 0, 0, 0, 0, 0, 1);
        b16.start = 1'b0;
        tick;
        chk16("p5_pair0", 1, 10, 11, 0, 0, 0, 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
